pwmcomp_16bits: RTL

PWMCOMP_16BITS -- requirements
Module: pwmcomp_16bits

---
 rtl/pwmcomp_16bits.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pwmcomp_16bits.sv
// pwmcomp_16bits -- PWM compare channel with complementary gate outputs and
// dead-time insertion.
//
// The carrier from a 16-bit PWM timer is compared against a shadowed duty
// reference. The registered comparison result (ref_q) steers a five-state FSM
// that drives a high-side and a low-side gate. Every handover between the two
// gates passes through a dead period during which both gates are low.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   ce          clock enable; low freezes all state (enable=0 still forces OFF)
//   carrier     unsigned 16-bit timer value
//   sync        one-cycle timer sync pulse; loads compare into the shadow
//   compare     unsigned duty reference
//   deadtime    dead-time length in ce-qualified cycles, minus one
//   enable      output enable; low forces the FSM to OFF on the next edge
//   pwm_h       high-side gate, active-high
//   pwm_l       low-side gate, active-high
//   dt_active   high while the FSM is in a dead-time state
//   cmp_shadow  compare value currently in use
//   state_dbg   current FSM state encoding (OFF=0, DT_TO_H=1, H_ON=2,
//               DT_TO_L=3, L_ON=4)

module pwmcomp_16bits (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] carrier,
  input  logic        sync,
  input  logic [15:0] compare,
  input  logic [7:0]  deadtime,
  input  logic        enable,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic        dt_active,
  output logic [15:0] cmp_shadow,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_DT_TO_H = 3'd1,
    S_H_ON    = 3'd2,
    S_DT_TO_L = 3'd3,
    S_L_ON    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] dt_cnt;
  logic [7:0] dt_cnt_nx;
  logic [7:0] dt_dec;
  logic       ref_q;

  // Shadow register and registered comparison. ref_q uses the shadow value
  // from before this edge, so a freshly loaded compare takes effect one edge
  // later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_shadow <= 16'd0;
      ref_q      <= 1'b0;
    end else if (ce) begin
      ref_q <= (carrier < cmp_shadow);
      if (sync) begin
        cmp_shadow <= compare;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_OFF;
      dt_cnt <= 8'd0;
    end else begin
      state  <= state_nx;
      dt_cnt <= dt_cnt_nx;
    end
  end

  // Saturating decrement of the dead-time counter.
  assign dt_dec = (dt_cnt == 8'd0) ? 8'd0 : (dt_cnt - 8'd1);

  // The dead-time counter keeps running when the target flips mid-period
  // (DT_TO_H <-> DT_TO_L): the dead period is one continuous gap, so a short
  // glitch on ref_q neither restarts nor extends it.
  always_comb begin
    state_nx  = state;
    dt_cnt_nx = dt_cnt;
    if (!enable) begin
      state_nx = S_OFF;
    end else if (ce) begin
      case (state)
        S_OFF: begin
          state_nx  = ref_q ? S_DT_TO_H : S_DT_TO_L;
          dt_cnt_nx = deadtime;
        end
        S_H_ON: begin
          if (!ref_q) begin
            state_nx  = S_DT_TO_L;
            dt_cnt_nx = deadtime;
          end
        end
        S_L_ON: begin
          if (ref_q) begin
            state_nx  = S_DT_TO_H;
            dt_cnt_nx = deadtime;
          end
        end
        S_DT_TO_H: begin
          if (!ref_q) begin
            state_nx  = S_DT_TO_L;
            dt_cnt_nx = dt_dec;
          end else if (dt_cnt == 8'd0) begin
            state_nx = S_H_ON;
          end else begin
            dt_cnt_nx = dt_dec;
          end
        end
        S_DT_TO_L: begin
          if (ref_q) begin
            state_nx  = S_DT_TO_H;
            dt_cnt_nx = dt_dec;
          end else if (dt_cnt == 8'd0) begin
            state_nx = S_L_ON;
          end else begin
            dt_cnt_nx = dt_dec;
          end
        end
        default: begin
          state_nx = S_OFF;
        end
      endcase
    end
  end

  // Gates decode only from the state register, so the async reset clears
  // them immediately and they can never be high together.
  assign pwm_h     = (state == S_H_ON);
  assign pwm_l     = (state == S_L_ON);
  assign dt_active = (state == S_DT_TO_H) || (state == S_DT_TO_L);
  assign state_dbg = state;

endmodule
